// File: rtl/calc_seq_pkg.sv
// Shared definitions for the calculator operation sequencer.
// Holds the ALU opcode constants, the sequencer state enum, the flags-register
// bit indices, the flag pattern written on an error trap, and small helpers
// for opcode legality and ALU flag reordering.
package calc_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StFlags,
    StDone,
    StErr
  } state_t;

  // Bit positions inside the flags register
  localparam int unsigned FLG_V = 0;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_Z = 3;

  // Written to the flags register when an operation is trapped: overflow only
  localparam logic [3:0] ERR_FLAGS = 4'b0001;

  // Any opcode above OP_OR is illegal
  function automatic logic op_illegal(input logic [2:0] op);
    return op > OP_OR;
  endfunction

  // ALU reports {Z,N,C,V}; place each bit at its flags-register index
  function automatic logic [3:0] map_alu_flags(input logic [3:0] alu_flags);
    logic [3:0] f;
    f        = '0;
    f[FLG_Z] = alu_flags[3];
    f[FLG_N] = alu_flags[2];
    f[FLG_C] = alu_flags[1];
    f[FLG_V] = alu_flags[0];
    return f;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Watchdog counter for the ALU wait phase.
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   clr_i      synchronous clear (wins over enable)
//   en_i       count this cycle
//   timeout_o  high on the enabled cycle in which the count reaches TIMEOUT
// TIMEOUT must lie in 1..255 (8-bit counter).
module seq_watchdog #(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  logic [7:0] cnt_q;

  // cnt_q holds the number of already completed enabled cycles, so the
  // current cycle is number cnt_q + 1.
  assign timeout_o = en_i && (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !timeout_o) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/calc_op_sequencer.sv
// Control FSM sequencing one ALU operation per request for the calculator
// datapath: accept request, start ALU, wait for completion (with watchdog),
// write the flags register, return the result. Divide-by-zero, illegal
// opcodes and ALU hangs are trapped in a sticky error state left by CLEAR.
// Ports:
//   CLK, RESET                 clock, asynchronous active-high reset
//   REQ/OPCODE/OPA/OPB/CHAIN   request side (sampled only when idle)
//   CLEAR                      synchronous abort, highest priority
//   ACK, BUSY                  request accepted pulse, not-idle indicator
//   ALU_A/B/OP, ALU_START      latched operands and start pulse to the ALU
//   ALU_DONE/RESULT/FLAGS      ALU completion strobe and its data
//   FLAGS_EN, FLAGS_IN         flags register write port
//   RESULT, RESULT_VALID       held result and completion pulse
//   ERROR                      high while trapped
// Build option: define SEQ_CHAIN_EN to let CHAIN=1 take operand A from RESULT.
module calc_op_sequencer
  import calc_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ,
  input  logic [2:0]       OPCODE,
  input  logic [WIDTH-1:0] OPA,
  input  logic [WIDTH-1:0] OPB,
  input  logic             CHAIN,
  input  logic             CLEAR,
  output logic             ACK,
  output logic             BUSY,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [2:0]       ALU_OP,
  output logic             ALU_START,
  input  logic             ALU_DONE,
  input  logic [WIDTH-1:0] ALU_RESULT,
  input  logic [3:0]       ALU_FLAGS,
  output logic             FLAGS_EN,
  output logic [3:0]       FLAGS_IN,
  output logic [WIDTH-1:0] RESULT,
  output logic             RESULT_VALID,
  output logic             ERROR
);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_cap_q, result_q;
  logic [2:0]       op_q;
  logic [3:0]       flags_cap_q;
  logic             err_entry_q;  // first cycle in StErr
  logic             wd_timeout;
  logic [WIDTH-1:0] a_sel;
  logic             req_bad;

`ifdef SEQ_CHAIN_EN
  assign a_sel = CHAIN ? result_q : OPA;
`else
  logic unused_chain;
  assign unused_chain = CHAIN;
  assign a_sel        = OPA;
`endif

  // Divide-by-zero always judged on OPB, even when A is chained
  assign req_bad = op_illegal(OPCODE) || ((OPCODE == OP_DIV) && (OPB == '0));

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .clr_i     (CLEAR || (state_q != StWait)),
    .en_i      (state_q == StWait),
    .timeout_o (wd_timeout)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_cap_q   <= '0;
      flags_cap_q <= '0;
      result_q    <= '0;
      err_entry_q <= 1'b0;
    end else if (CLEAR) begin
      state_q     <= StIdle;
      err_entry_q <= 1'b0;
    end else begin
      err_entry_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (REQ) begin
            a_q         <= a_sel;
            b_q         <= OPB;
            op_q        <= OPCODE;
            state_q     <= req_bad ? StErr : StIssue;
            err_entry_q <= req_bad;
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          // Completion wins over a simultaneous watchdog expiry
          if (ALU_DONE) begin
            res_cap_q   <= ALU_RESULT;
            flags_cap_q <= ALU_FLAGS;
            state_q     <= StFlags;
          end else if (wd_timeout) begin
            state_q     <= StErr;
            err_entry_q <= 1'b1;
          end
        end
        StFlags: begin
          result_q <= res_cap_q;  // visible together with RESULT_VALID
          state_q  <= StDone;
        end
        StDone:  state_q <= StIdle;
        StErr:   state_q <= StErr;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    ACK          = (state_q == StIdle) && REQ && !CLEAR && !RESET;
    BUSY         = (state_q != StIdle);
    ALU_START    = (state_q == StIssue) && !CLEAR;
    RESULT_VALID = (state_q == StDone) && !CLEAR;
    ERROR        = (state_q == StErr);
    FLAGS_EN     = 1'b0;
    FLAGS_IN     = '0;
    if (!CLEAR) begin
      if (state_q == StFlags) begin
        FLAGS_EN = 1'b1;
        FLAGS_IN = map_alu_flags(flags_cap_q);
      end else if ((state_q == StErr) && err_entry_q) begin
        FLAGS_EN = 1'b1;
        FLAGS_IN = ERR_FLAGS;
      end
    end
  end

  assign ALU_A  = a_q;
  assign ALU_B  = b_q;
  assign ALU_OP = op_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
module tb_calc_op_sequencer;

  localparam int TO = 31;
`ifdef SEQ_CHAIN_EN
  localparam bit CHAIN_ON = 1'b1;
`else
  localparam bit CHAIN_ON = 1'b0;
`endif

  logic       CLK, RESET, REQ, CHAIN, CLEAR, ALU_DONE;
  logic [2:0] OPCODE, ALU_OP;
  logic [7:0] OPA, OPB, ALU_A, ALU_B, ALU_RESULT, RESULT;
  logic [3:0] ALU_FLAGS, FLAGS_IN;
  logic       ACK, BUSY, ALU_START, FLAGS_EN, RESULT_VALID, ERROR;

  calc_op_sequencer #(
    .WIDTH   (8),
    .TIMEOUT (TO)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .REQ          (REQ),
    .OPCODE       (OPCODE),
    .OPA          (OPA),
    .OPB          (OPB),
    .CHAIN        (CHAIN),
    .CLEAR        (CLEAR),
    .ACK          (ACK),
    .BUSY         (BUSY),
    .ALU_A        (ALU_A),
    .ALU_B        (ALU_B),
    .ALU_OP       (ALU_OP),
    .ALU_START    (ALU_START),
    .ALU_DONE     (ALU_DONE),
    .ALU_RESULT   (ALU_RESULT),
    .ALU_FLAGS    (ALU_FLAGS),
    .FLAGS_EN     (FLAGS_EN),
    .FLAGS_IN     (FLAGS_IN),
    .RESULT       (RESULT),
    .RESULT_VALID (RESULT_VALID),
    .ERROR        (ERROR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One transaction: stimulus plus expected outcome, cycles relative to ACK.
  // dly = cycles from ALU_START to ALU_DONE, 0 = ALU never answers. -1 = never.
  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    logic       ch;
    int         dly;
    logic [3:0] fl;
    logic [7:0] res;
    logic       e_err;
    int         e_st, e_fe;
    logic [3:0] e_fin;
    int         e_rv;
    logic [7:0] e_result, e_a;
  } txn_t;

  int n_err = 0;
  int n_chk = 0;
  logic [7:0] model_result;

  logic ack_s, busy_s, start_s, fen_s, rv_s, err_s;
  logic [3:0] fin_s;
  logic [7:0] res_s, alua_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sample the current cycle just before leaving it, then advance one clock.
  task automatic cyc();
    #1;
    ack_s = ACK; busy_s = BUSY; start_s = ALU_START; fen_s = FLAGS_EN;
    rv_s = RESULT_VALID; err_s = ERROR; fin_s = FLAGS_IN; res_s = RESULT; alua_s = ALU_A;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [7:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a * b;
      3'd3: r = (b == 0) ? 8'd0 : a / b;
      3'd4: r = a & b;
      3'd5: r = a | b;
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  // Outcome computed from the operation rules: trap, watchdog, or completion.
  function automatic txn_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic ch, input int dly, input logic [3:0] fl);
    txn_t t;
    logic [7:0] ea;
    ea = (CHAIN_ON && ch) ? model_result : a;
    t.op = op; t.a = a; t.b = b; t.ch = ch; t.dly = dly; t.fl = fl;
    t.res = alu_ref(op, ea, b);
    t.e_a = ea;
    if (op >= 3'd6 || (op == 3'd3 && b == 8'd0)) begin
      t.e_err = 1; t.e_st = -1; t.e_fe = 1; t.e_fin = 4'b0001; t.e_rv = -1;
      t.e_result = model_result;
    end else if (dly >= 1 && dly <= TO) begin
      t.e_err = 0; t.e_st = 1; t.e_fe = dly + 2; t.e_fin = fl; t.e_rv = dly + 3;
      t.e_result = t.res;
    end else begin
      t.e_err = 1; t.e_st = 1; t.e_fe = TO + 2; t.e_fin = 4'b0001; t.e_rv = -1;
      t.e_result = model_result;
    end
    return t;
  endfunction

  function automatic txn_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic ch, input int dly, input logic [3:0] fl,
                              input logic [7:0] res, input logic e_err, input int e_st,
                              input int e_fe, input logic [3:0] e_fin, input int e_rv,
                              input logic [7:0] e_result, input logic [7:0] e_a);
    txn_t t;
    t.op = op; t.a = a; t.b = b; t.ch = ch; t.dly = dly; t.fl = fl; t.res = res;
    t.e_err = e_err; t.e_st = e_st; t.e_fe = e_fe; t.e_fin = e_fin; t.e_rv = e_rv;
    t.e_result = e_result; t.e_a = e_a;
    return t;
  endfunction

  task automatic run_txn(input txn_t t);
    int st, fe, rv, fen_n;
    logic [3:0] fin;
    logic errseen;
    logic [7:0] alua;
    st = -1; fe = -1; rv = -1; fen_n = 0; fin = '0; errseen = 0; alua = '0;
    REQ = 1; OPCODE = t.op; OPA = t.a; OPB = t.b; CHAIN = t.ch;
    cyc();
    chk("ack", ack_s, 1);
    REQ = 0;
    for (int c = 1; c <= TO + 6; c++) begin
      ALU_DONE   = (t.dly != 0) && (st >= 0) && (c == st + t.dly);
      ALU_RESULT = t.res;
      ALU_FLAGS  = t.fl;
      cyc();
      if (start_s) begin
        if (st < 0) st = c;
        alua = alua_s;
      end
      if (fen_s) begin
        fen_n++;
        if (fe < 0) begin fe = c; fin = fin_s; end
      end
      if (rv_s) rv = c;
      if (err_s) begin errseen = 1; break; end
      if (!busy_s) break;
    end
    ALU_DONE = 0;
    chk("error", errseen, t.e_err);
    chk("start_cycle", st, t.e_st);
    chk("flags_en_cycle", fe, t.e_fe);
    chk("flags_en_count", fen_n, 1);
    chk("flags_in", fin, t.e_fin);
    chk("valid_cycle", rv, t.e_rv);
    chk("result", res_s, t.e_result);
    if (t.e_st >= 0) chk("alu_a", alua, t.e_a);
    if (t.e_err) begin
      CLEAR = 1;
      cyc();
      chk("err_no_reflag", fen_s, 0);
      CLEAR = 0;
      cyc();
      chk("clear_error", err_s, 0);
      chk("clear_busy", busy_s, 0);
    end
    model_result = t.e_result;
  endtask

  txn_t vec[$];

  initial begin
    RESET = 1; REQ = 0; OPCODE = 0; OPA = 0; OPB = 0; CHAIN = 0; CLEAR = 0;
    ALU_DONE = 0; ALU_RESULT = 0; ALU_FLAGS = 0;
    model_result = 8'h00;
    @(posedge CLK); #1;
    chk("rst_outputs", {ACK, BUSY, ALU_START, FLAGS_EN, RESULT_VALID, ERROR}, 0);
    chk("rst_alu_in", {ALU_A, ALU_B, ALU_OP}, 0);
    chk("rst_flags_result", {FLAGS_IN, RESULT}, 0);
    @(posedge CLK); #1;
    RESET = 0;
    @(posedge CLK); #1;

    //        op  a      b      ch dly     fl       res    err st  fe      fin      rv  result a
    vec.push_back(mk(0, 8'h7F, 8'h01, 0, 1,      4'b0101, 8'h80, 0, 1,  3,      4'b0101, 4,  8'h80, 8'h7F));
    vec.push_back(mk(3, 8'h12, 8'h00, 0, 1,      4'b0000, 8'h00, 1, -1, 1,      4'b0001, -1, 8'h80, 8'h12));
    vec.push_back(mk(7, 8'h33, 8'h44, 0, 1,      4'b0000, 8'h00, 1, -1, 1,      4'b0001, -1, 8'h80, 8'h33));
    vec.push_back(mk(1, 8'h10, 8'h03, 0, 4,      4'b0000, 8'h0D, 0, 1,  6,      4'b0000, 7,  8'h0D, 8'h10));
    vec.push_back(mk(2, 8'h05, 8'h06, 0, 0,      4'b1111, 8'h1E, 1, 1,  TO + 2, 4'b0001, -1, 8'h0D, 8'h05));
    vec.push_back(mk(3, 8'h09, 8'h03, 0, TO,     4'b0010, 8'h03, 0, 1,  TO + 2, 4'b0010, TO + 3, 8'h03, 8'h09));
    vec.push_back(mk(4, 8'hF0, 8'h3C, 0, TO + 1, 4'b1000, 8'h30, 1, 1,  TO + 2, 4'b0001, -1, 8'h03, 8'hF0));
    vec.push_back(mk(6, 8'h01, 8'h01, 0, 1,      4'b0000, 8'h00, 1, -1, 1,      4'b0001, -1, 8'h03, 8'h01));
    vec.push_back(mk(5, 8'h00, 8'h00, 0, 2,      4'b1000, 8'h00, 0, 1,  4,      4'b1000, 5,  8'h00, 8'h00));
    vec.push_back(mk(0, 8'h03, 8'h04, 0, 1,      4'b0000, 8'h07, 0, 1,  3,      4'b0000, 4,  8'h07, 8'h03));
`ifdef SEQ_CHAIN_EN
    vec.push_back(mk(2, 8'h55, 8'h02, 1, 1,      4'b0000, 8'h0E, 0, 1,  3,      4'b0000, 4,  8'h0E, 8'h07));
    vec.push_back(mk(3, 8'h10, 8'h00, 1, 1,      4'b0000, 8'h00, 1, -1, 1,      4'b0001, -1, 8'h0E, 8'h0E));
`else
    vec.push_back(mk(2, 8'h55, 8'h02, 1, 1,      4'b0000, 8'hAA, 0, 1,  3,      4'b0000, 4,  8'hAA, 8'h55));
    vec.push_back(mk(3, 8'h10, 8'h00, 1, 1,      4'b0000, 8'h00, 1, -1, 1,      4'b0001, -1, 8'hAA, 8'h10));
`endif
    foreach (vec[i]) run_txn(vec[i]);

    // CLEAR together with REQ in IDLE: no acceptance
    REQ = 1; CLEAR = 1; OPCODE = 0;
    cyc();
    chk("clear_blocks_ack", ack_s, 0);
    REQ = 0; CLEAR = 0;
    cyc();
    chk("clear_blocks_busy", busy_s, 0);

    // CLEAR during ISSUE suppresses the start pulse
    REQ = 1; OPCODE = 0; OPA = 8'h01; OPB = 8'h02; CHAIN = 0;
    cyc();
    REQ = 0; CLEAR = 1;
    cyc();
    chk("clear_issue_start", start_s, 0);
    CLEAR = 0;
    cyc();
    chk("clear_issue_busy", busy_s, 0);

    // CLEAR during WAIT, then a late ALU_DONE
    REQ = 1; OPCODE = 1; OPA = 8'h20; OPB = 8'h01;
    cyc();
    REQ = 0;
    cyc();
    cyc();
    CLEAR = 1;
    cyc();
    chk("clear_wait_flags", {fen_s, rv_s}, 0);
    CLEAR = 0; ALU_DONE = 1; ALU_RESULT = 8'h99; ALU_FLAGS = 4'b1111;
    cyc();
    chk("late_done_busy", busy_s, 0);
    ALU_DONE = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("late_done_ignored", {fen_s, rv_s, busy_s}, 0);
    end
    chk("clear_result_kept", res_s, model_result);

    // RESET during WAIT, then a late ALU_DONE
    REQ = 1; OPCODE = 0; OPA = 8'h01; OPB = 8'h01;
    cyc();
    REQ = 0;
    cyc();
    cyc();
    RESET = 1;
    #1;
    chk("rst_mid_busy", BUSY, 0);
    chk("rst_mid_result", {RESULT, ALU_A}, 0);
    model_result = 8'h00;
    cyc();
    RESET = 0; ALU_DONE = 1; ALU_RESULT = 8'h99;
    cyc();
    chk("rst_late_done", {fen_s, rv_s, busy_s}, 0);
    ALU_DONE = 0;
    cyc();
    chk("rst_late_done2", {fen_s, rv_s, busy_s}, 0);
    chk("rst_result_zero", res_s, 0);

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      int d, r;
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      r  = $urandom_range(0, 9);
      d  = (r == 0) ? 0 : (r == 1) ? TO : (r == 2) ? TO + 1 : $urandom_range(1, 6);
      run_txn(model(op, a, b, 1'($urandom), d, 4'($urandom)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Control FSM that sequences one ALU operation per request for the pocket-calculator datapath.
- Accepts an opcode and operands from the keypad/decoder side and issues them to the ALU with a start pulse.
- Waits for ALU completion, then writes the ALU status bits into the flags register through its enable/data inputs.
- Returns the result with a valid pulse; traps divide-by-zero, illegal opcodes and ALU hangs.

Parameters:
WIDTH, 8, operand/result width in bits
TIMEOUT, 31, max cycles spent in WAIT before the watchdog error (1..255)

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  asynchronous, active-high reset
REQ  input  1  operation request, level; sampled only in IDLE
OPCODE  input  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6/7 illegal
OPA  input  WIDTH  operand A
OPB  input  WIDTH  operand B
CHAIN  input  1  use previous result as A (only with SEQ_CHAIN_EN)
CLEAR  input  1  synchronous abort/clear
ACK  output  1  one-cycle pulse when a request is accepted
BUSY  output  1  high in every state except IDLE
ALU_A  output  WIDTH  latched operand A to the ALU
ALU_B  output  WIDTH  latched operand B to the ALU
ALU_OP  output  3  latched opcode to the ALU
ALU_START  output  1  one-cycle start pulse
ALU_DONE  input  1  ALU completion strobe
ALU_RESULT  input  WIDTH  ALU result, valid with ALU_DONE
ALU_FLAGS  input  4  {Z,N,C,V}, valid with ALU_DONE
FLAGS_EN  output  1  one-cycle write enable to the flags register
FLAGS_IN  output  4  bit0 overflow, bit1 carry, bit2 negative, bit3 zero
RESULT  output  WIDTH  last completed result, held
RESULT_VALID  output  1  one-cycle pulse on completion
ERROR  output  1  sticky error indicator

Behaviour:
- Reset (async, active-high): state IDLE. All outputs 0, including ALU_A/B/OP, RESULT, the latched operands and the watchdog count.
- States: IDLE, ISSUE, WAIT, FLAGS, DONE, ERR.
- IDLE:
  - When REQ=1, latch OPCODE/OPA/OPB and pulse ACK in the same cycle.
  - Next state: ERR if OPCODE ≥ 6, or if OPCODE=DIV and OPB=0. Otherwise ISSUE.
- ISSUE: ALU_START=1 for exactly this cycle; go to WAIT.
- ALU inputs: ALU_A/B/OP are driven from the latches and stay stable from ISSUE until the next acceptance.
- WAIT:
  - ALU_DONE is sampled only here; ALU_DONE in any other state is ignored.
  - On ALU_DONE, capture ALU_RESULT and ALU_FLAGS, go to FLAGS.
  - The watchdog counts cycles in WAIT. If the count reaches TIMEOUT without ALU_DONE, go to ERR.
  - ALU_DONE on the same cycle the count reaches TIMEOUT: completion wins.
- FLAGS: FLAGS_EN=1 and FLAGS_IN = captured flags for one cycle; go to DONE.
- DONE: RESULT updated and RESULT_VALID=1 for one cycle; go to IDLE. REQ is sampled again from the following cycle.
- ERR:
  - On entry cycle only: FLAGS_EN=1 with FLAGS_IN=4'b0001 (overflow set).
  - ERROR=1 while in ERR; REQ is ignored.
  - RESULT is not modified on any error.
- CLEAR:
  - In any state, the next state is IDLE, ERROR is cleared and the watchdog resets.
  - No ALU_START, FLAGS_EN or RESULT_VALID is emitted that cycle.
  - CLEAR has priority over REQ and ALU_DONE.
- Minimum latency: REQ accepted at cycle 0, ALU_START at 1, ALU_DONE at 2, FLAGS_EN at 3, RESULT_VALID at 4.
- Reset mid-operation: immediate return to IDLE; the pending ALU result is discarded.
- Widths: operands pass through unmodified; the sequencer performs no arithmetic apart from the watchdog counter.

Optional Feature:
SEQ_CHAIN_EN
- Defined: when a request is accepted with CHAIN=1, the latched A is the current RESULT and OPA is ignored. The divide-by-zero check still uses OPB.
- Undefined: the CHAIN port exists but is ignored, and A always comes from OPA.

Decomposition:
- Package calc_seq_pkg holds:
  - opcode constants (OP_ADD..OP_OR);
  - the state enum;
  - flag bit indices FLG_V=0, FLG_C=1, FLG_N=2, FLG_Z=3;
  - the ERR flag pattern.
- Sub-module seq_watchdog: counter with clear/enable and a timeout output, parameterised by TIMEOUT.

Test Plan:
- ADD, OPA=8'h7F, OPB=8'h01, ALU_DONE one cycle after start with flags 4'b0101 -> ACK@0, ALU_START@1, FLAGS_EN@3 with FLAGS_IN=4'b0101, RESULT_VALID@4 with RESULT=8'h80.
- DIV, OPB=0 -> ACK, no ALU_START, FLAGS_EN one cycle with 4'b0001, ERROR=1. CLEAR -> ERROR=0, BUSY=0 next cycle.
- OPCODE=7 -> ERR path as above, RESULT unchanged from its prior value.
- ALU never asserts ALU_DONE, TIMEOUT=31 -> ERR exactly 31 cycles after WAIT entry. ALU_DONE injected at cycle 31 instead -> normal completion.
- CLEAR, then RESET, asserted during WAIT -> IDLE, no FLAGS_EN or RESULT_VALID. A late ALU_DONE after that is ignored.
- SEQ_CHAIN_EN: ADD 3+4 = 7, then CHAIN=1 with MUL and OPB=2 -> ALU_A=7, RESULT=14. Without the macro -> ALU_A=OPA.
